// File: rtl/psum_collector.sv
// psum_collector: FWFT psum FIFO with row tagging, valid/ready output and stall back-pressure
//   Ports: clk, rst (async active-low), flush (sync clear), Psum/done_psum (MAC input),
//   stall (FIFO full), out_data/out_last/out_valid/out_ready (output handshake), count (occupancy).
//   Option: define PSUM_RELU_EN to clamp negative psums to zero at the write port.
module psum_collector #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 4,
  parameter int OUTS_PER_ROW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         Psum,
  input  logic                     done_psum,
  output logic                     stall,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = OUTS_PER_ROW > 1 ? $clog2(OUTS_PER_ROW) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIDTH-1:0] wdata;
  logic             push, pop, last;
  assign stall     = count_q == CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count     = count_q;
  // Head is gated so the outputs read zero while empty, even though storage is never cleared.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & tag_q[rd_ptr_q];
  assign push      = done_psum & ~stall & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign last      = row_q == RW'(OUTS_PER_ROW - 1);
`ifdef PSUM_RELU_EN
  assign wdata = Psum[WIDTH-1] ? '0 : Psum;
`else
  assign wdata = Psum;
`endif
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    row_d    = flush ? '0 : !push ? row_q : last ? '0 : row_q + RW'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      row_q    <= row_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
      tag_q[wr_ptr_q] <= last;
    end
  end
endmodule
